// File: rtl/imem_read_arbiter_pkg.sv
// Shared types for the instruction/unified memory read-channel arbiter.
package imem_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'b00,
    ArbAddr = 2'b01,
    ArbResp = 2'b10
  } arb_state_e;

  // Owner encoding matches the one-hot grant vector {LS, IF}.
  typedef enum logic [1:0] {
    OwnNone = 2'b00,
    OwnIF   = 2'b01,
    OwnLS   = 2'b10
  } arb_owner_e;

  localparam logic [1:0] RespOKAY = 2'b00;

endpackage

// File: rtl/imem_read_arbiter_rr_arbiter2.sv
// Two-request round-robin pick; grant is one-hot {LS, IF}, last_grant likewise.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the requester that did not win last time goes first.
    if (&req) gnt = (last_grant == 2'b10) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/imem_read_arbiter.sv
// Round-robin sharing of one AXI4-Lite read channel between fetch (IF) and load (LS).
module imem_read_arbiter
  import imem_read_arbiter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit LS_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_if_arvalid,
  output logic            o_if_arready,
  input  logic [XLEN-1:0] i_if_araddr,
  input  logic [2:0]      i_if_arprot,
  output logic            o_if_rvalid,
  input  logic            i_if_rready,
  output logic [XLEN-1:0] o_if_rdata,
  output logic [1:0]      o_if_rresp,
  input  logic            i_ls_arvalid,
  output logic            o_ls_arready,
  input  logic [XLEN-1:0] i_ls_araddr,
  input  logic [2:0]      i_ls_arprot,
  output logic            o_ls_rvalid,
  input  logic            i_ls_rready,
  output logic [XLEN-1:0] o_ls_rdata,
  output logic [1:0]      o_ls_rresp,
  output logic            o_m_arvalid,
  input  logic            i_m_arready,
  output logic [XLEN-1:0] o_m_araddr,
  output logic [2:0]      o_m_arprot,
  input  logic            i_m_rvalid,
  output logic            o_m_rready,
  input  logic [XLEN-1:0] i_m_rdata,
  input  logic [1:0]      i_m_rresp,
  output logic [1:0]      o_owner
);

  localparam arb_owner_e LastInit = LS_FIRST ? OwnIF : OwnLS;

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  arb_owner_e      last_grant_q, last_grant_d;
  logic            arvalid_q, arvalid_d;
  logic [XLEN-1:0] araddr_q, araddr_d;
  logic [2:0]      arprot_q, arprot_d;
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            in_idle;
  logic            in_resp;

  // Requests are masked in reset so no arready can leak out while rstn is low.
  assign req     = {i_ls_arvalid, i_if_arvalid} & {2{rstn}};
  assign in_idle = (state_q == ArbIdle);
  assign in_resp = (state_q == ArbResp);

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign o_if_arready = in_idle & gnt[0];
  assign o_ls_arready = in_idle & gnt[1];

  assign o_if_rvalid = in_resp & (owner_q == OwnIF) & i_m_rvalid;
  assign o_ls_rvalid = in_resp & (owner_q == OwnLS) & i_m_rvalid;
  assign o_m_rready  = in_resp & (((owner_q == OwnIF) & i_if_rready) |
                                  ((owner_q == OwnLS) & i_ls_rready));

  assign o_if_rdata = rstn ? i_m_rdata : '0;
  assign o_ls_rdata = rstn ? i_m_rdata : '0;
  assign o_if_rresp = rstn ? i_m_rresp : RespOKAY;
  assign o_ls_rresp = rstn ? i_m_rresp : RespOKAY;

  assign o_m_arvalid = arvalid_q;
  assign o_m_araddr  = araddr_q;
  assign o_m_arprot  = arprot_q;
  assign o_owner     = owner_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arprot_d     = arprot_q;
    case (state_q)
      ArbIdle: begin
        if (|gnt) begin
          owner_d   = arb_owner_e'(gnt);
          araddr_d  = gnt[1] ? i_ls_araddr : i_if_araddr;
          arprot_d  = gnt[1] ? i_ls_arprot : i_if_arprot;
          arvalid_d = 1'b1;
          state_d   = ArbAddr;
        end
      end
      ArbAddr: begin
        if (arvalid_q && i_m_arready) begin
          arvalid_d = 1'b0;
          state_d   = ArbResp;
        end
      end
      ArbResp: begin
        if (i_m_rvalid && o_m_rready) begin
          last_grant_d = owner_q;
          owner_d      = OwnNone;
          state_d      = ArbIdle;
        end
      end
      default: begin
        state_d   = ArbIdle;
        owner_d   = OwnNone;
        arvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ArbIdle;
      owner_q      <= OwnNone;
      last_grant_q <= LastInit;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arprot_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arprot_q     <= arprot_d;
    end
  end

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction model.
module tb_imem_read_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            i_if_arvalid, o_if_arready, o_if_rvalid, i_if_rready;
  logic [XLEN-1:0] i_if_araddr, o_if_rdata;
  logic [2:0]      i_if_arprot;
  logic [1:0]      o_if_rresp;
  logic            i_ls_arvalid, o_ls_arready, o_ls_rvalid, i_ls_rready;
  logic [XLEN-1:0] i_ls_araddr, o_ls_rdata;
  logic [2:0]      i_ls_arprot;
  logic [1:0]      o_ls_rresp;
  logic            o_m_arvalid, i_m_arready, i_m_rvalid, o_m_rready;
  logic [XLEN-1:0] o_m_araddr, i_m_rdata;
  logic [2:0]      o_m_arprot;
  logic [1:0]      i_m_rresp, o_owner;

  always #5 clk = ~clk;

  imem_read_arbiter #(.XLEN(XLEN), .LS_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .i_if_arvalid(i_if_arvalid), .o_if_arready(o_if_arready), .i_if_araddr(i_if_araddr),
    .i_if_arprot(i_if_arprot), .o_if_rvalid(o_if_rvalid), .i_if_rready(i_if_rready),
    .o_if_rdata(o_if_rdata), .o_if_rresp(o_if_rresp),
    .i_ls_arvalid(i_ls_arvalid), .o_ls_arready(o_ls_arready), .i_ls_araddr(i_ls_araddr),
    .i_ls_arprot(i_ls_arprot), .o_ls_rvalid(o_ls_rvalid), .i_ls_rready(i_ls_rready),
    .o_ls_rdata(o_ls_rdata), .o_ls_rresp(o_ls_rresp),
    .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready), .o_m_araddr(o_m_araddr),
    .o_m_arprot(o_m_arprot), .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready),
    .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp), .o_owner(o_owner)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction model: phase 0 free, 1 address issued, 2 awaiting response.
  // Requesters: 0 none, 1 IF, 2 LS.
  int          m_phase, m_owner, m_last;
  logic [31:0] m_addr;
  logic [2:0]  m_prot;
  bit          acc_if, acc_ls;
  int          if_skip, ls_skip;
  logic [31:0] ar_log[$];

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 1;  // LS wins the first tie
    if_skip = 0; ls_skip = 0;
  endtask

  task automatic check_cycle();
    int win;
    bit exp_rready;
    win = 0;
    if (m_phase == 0) begin
      if (i_if_arvalid && i_ls_arvalid) win = (m_last == 1) ? 2 : 1;
      else if (i_if_arvalid) win = 1;
      else if (i_ls_arvalid) win = 2;
    end
    exp_rready = (m_phase == 2) && ((m_owner == 1 && i_if_rready) || (m_owner == 2 && i_ls_rready));
    chk("if_arready", o_if_arready, win == 1);
    chk("ls_arready", o_ls_arready, win == 2);
    chk("owner", o_owner, m_owner);
    chk("m_arvalid", o_m_arvalid, m_phase == 1);
    if (m_phase == 1) begin
      chk("m_araddr", o_m_araddr, m_addr);
      chk("m_arprot", o_m_arprot, m_prot);
    end
    chk("if_rvalid", o_if_rvalid, (m_phase == 2) && (m_owner == 1) && i_m_rvalid);
    chk("ls_rvalid", o_ls_rvalid, (m_phase == 2) && (m_owner == 2) && i_m_rvalid);
    chk("m_rready", o_m_rready, exp_rready);
    chk("if_rdata", o_if_rdata, i_m_rdata);
    chk("ls_rresp", o_ls_rresp, i_m_rresp);
    acc_if = o_if_arready;
    acc_ls = o_ls_arready;
    if (o_ls_arready && i_if_arvalid) begin
      if_skip++;
      chk("if_starve", if_skip <= 1, 1);
    end
    if (o_if_arready && i_ls_arvalid) begin
      ls_skip++;
      chk("ls_starve", ls_skip <= 1, 1);
    end
    if (o_if_arready) if_skip = 0;
    if (o_ls_arready) ls_skip = 0;
    if (o_m_arvalid && i_m_arready) ar_log.push_back(o_m_araddr);
    case (m_phase)
      0: if (win != 0) begin
        m_phase = 1;
        m_owner = win;
        m_addr  = (win == 1) ? i_if_araddr : i_ls_araddr;
        m_prot  = (win == 1) ? i_if_arprot : i_ls_arprot;
      end
      1: if (i_m_arready) m_phase = 2;
      2: if (i_m_rvalid && exp_rready) begin
        m_phase = 0;
        m_last  = m_owner;
        m_owner = 0;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic sample();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    i_m_arready = 1'b1; i_m_rvalid = 1'b1; i_if_rready = 1'b1; i_ls_rready = 1'b1;
    while ((m_phase != 0 || i_if_arvalid || i_ls_arvalid) && n < max_cyc) begin
      sample();
      drive_pt();
      if (acc_if) i_if_arvalid = 1'b0;
      if (acc_ls) i_ls_arvalid = 1'b0;
      n++;
    end
    chk("drain_timeout", n < max_cyc, 1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_if_arvalid = 1'b1; i_if_araddr = 32'h0; i_if_arprot = 3'b100; i_if_rready = 1'b1;
    i_ls_arvalid = 1'b1; i_ls_araddr = 32'h0; i_ls_arprot = 3'b000; i_ls_rready = 1'b1;
    i_m_arready = 1'b1; i_m_rvalid = 1'b1; i_m_rdata = 32'hA5A5_A5A5; i_m_rresp = 2'b10;
    model_reset();

    // Outputs held at zero in reset even with live inputs.
    #12;
    chk("rst_if_arready", o_if_arready, 0);
    chk("rst_ls_arready", o_ls_arready, 0);
    chk("rst_m_arvalid", o_m_arvalid, 0);
    chk("rst_m_araddr", o_m_araddr, 0);
    chk("rst_m_arprot", o_m_arprot, 0);
    chk("rst_owner", o_owner, 0);
    chk("rst_rvalid", {o_if_rvalid, o_ls_rvalid, o_m_rready}, 0);
    chk("rst_rdata", o_if_rdata | o_ls_rdata, 0);
    chk("rst_rresp", {o_if_rresp, o_ls_rresp}, 0);
    i_if_arvalid = 1'b0; i_ls_arvalid = 1'b0; i_m_rvalid = 1'b0; i_m_rresp = 2'b00;
    @(negedge clk); rstn = 1'b1;
    drive_pt();

    // IF only, zero-wait memory.
    i_if_arvalid = 1'b1; i_if_araddr = 32'h0; i_if_arprot = 3'b100;
    sample();
    chk("t1_if_arready", o_if_arready, 1);
    drive_pt();
    i_if_arvalid = 1'b0;
    sample();
    chk("t1_m_arvalid", o_m_arvalid, 1);
    drive_pt();
    i_m_rvalid = 1'b1; i_m_rdata = 32'h0000_0013;
    sample();
    chk("t1_if_rvalid", o_if_rvalid, 1);
    chk("t1_if_rdata", o_if_rdata, 32'h13);
    chk("t1_ls_rvalid", o_ls_rvalid, 0);
    drive_pt();
    i_m_rvalid = 1'b0;
    sample();
    chk("t1_owner_none", o_owner, 0);
    drive_pt();

    // Both request continuously: strict alternation starting with LS.
    i_if_araddr = 32'h0000_0100; i_ls_araddr = 32'h0000_2000;
    i_if_arvalid = 1'b1; i_ls_arvalid = 1'b1;
    i_m_rvalid = 1'b1; i_m_arready = 1'b1;
    ar_log.delete();
    repeat (13) begin
      sample();
      drive_pt();
    end
    chk("t2_count", ar_log.size() >= 4, 1);
    chk("t2_addr0", ar_log[0], 32'h2000);
    chk("t2_addr1", ar_log[1], 32'h0100);
    chk("t2_addr2", ar_log[2], 32'h2000);
    chk("t2_addr3", ar_log[3], 32'h0100);
    run_until_idle(20);

    // Memory stalls arready for 5 cycles, then IF holds rready low for 3.
    i_m_rvalid = 1'b0; i_m_arready = 1'b0;
    i_if_arvalid = 1'b1; i_if_araddr = 32'h0000_0440; i_if_arprot = 3'b101;
    sample();
    drive_pt();
    i_if_arvalid = 1'b0;
    repeat (5) begin
      sample();
      chk("t3_hold_addr", o_m_araddr, 32'h440);
      drive_pt();
    end
    i_m_arready = 1'b1;
    sample();
    drive_pt();
    i_m_arready = 1'b0;
    i_m_rvalid = 1'b1; i_m_rdata = 32'hDEAD_BEEF; i_if_rready = 1'b0;
    repeat (3) begin
      sample();
      chk("t4_rready_low", o_m_rready, 0);
      chk("t4_owner_if", o_owner, 1);
      drive_pt();
    end
    i_if_rready = 1'b1;
    sample();
    chk("t4_rdata", o_if_rdata, 32'hDEAD_BEEF);
    drive_pt();
    sample();
    drive_pt();

    // LS completes (last grant becomes LS), then reset lands mid-ADDR of an IF request.
    i_ls_arvalid = 1'b1; i_ls_araddr = 32'h0000_3000; i_ls_arprot = 3'b000;
    run_until_idle(20);
    i_m_arready = 1'b0; i_m_rvalid = 1'b0;
    i_if_arvalid = 1'b1; i_if_araddr = 32'h0000_0500;
    sample();
    drive_pt();
    i_ls_arvalid = 1'b1;
    sample();
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_arvalid", o_m_arvalid, 0);
    chk("t5_rst_owner", o_owner, 0);
    chk("t5_rst_arready", {o_if_arready, o_ls_arready}, 0);
    model_reset();
    @(posedge clk);
    #2 rstn = 1'b1;
    sample();
    chk("t5_ls_first", o_ls_arready, 1);
    drive_pt();
    i_ls_arvalid = 1'b0;
    run_until_idle(20);

    // Stray rvalid in IDLE is ignored; SLVERR forwarded unchanged.
    i_m_rvalid = 1'b1; i_m_rresp = 2'b10; i_m_arready = 1'b1;
    repeat (2) begin
      sample();
      drive_pt();
    end
    i_if_arvalid = 1'b1; i_if_araddr = 32'h0000_0600;
    i_m_rvalid = 1'b0;
    sample();
    drive_pt();
    i_if_arvalid = 1'b0;
    sample();
    drive_pt();
    i_m_rvalid = 1'b1; i_m_rdata = 32'hBAD0_BAD0; i_m_rresp = 2'b10;
    sample();
    chk("t6_slverr", o_if_rresp, 2'b10);
    chk("t6_rvalid", o_if_rvalid, 1);
    drive_pt();

    // Randomized traffic.
    i_m_rresp = 2'b00;
    repeat (3000) begin
      sample();
      drive_pt();
      if (acc_if || !i_if_arvalid) begin
        i_if_arvalid = ($urandom % 3) == 0;
        i_if_araddr  = $urandom & 32'hFFFF_FFFC;
        i_if_arprot  = 3'($urandom % 8);
      end
      if (acc_ls || !i_ls_arvalid) begin
        i_ls_arvalid = ($urandom % 3) == 0;
        i_ls_araddr  = $urandom & 32'hFFFF_FFFC;
        i_ls_arprot  = 3'($urandom % 8);
      end
      i_m_arready = ($urandom % 3) != 0;
      i_m_rvalid  = ($urandom % 2) != 0;
      i_m_rdata   = $urandom;
      i_m_rresp   = 2'($urandom % 4);
      i_if_rready = ($urandom % 4) != 0;
      i_ls_rready = ($urandom % 4) != 0;
    end
    run_until_idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_read_arbiter.md
Name: imem_read_arbiter

Overview:
- Shares the single AXI4-Lite read channel (AR + R) of instruction/unified memory between two requesters: instruction fetch (IF, driven by the PC/fetch logic) and load unit (LS).
- Round-robin arbitration, one outstanding transaction at a time.
- Latches the winning address and protection, drives the downstream AR channel, then routes the R response back to the owner.
- Sits between core fetch/load logic and the memory bus interconnect.

Parameters:
- XLEN, 32, address/data width.
- LS_FIRST, 1, which requester wins the first tie after reset (1 = LS, 0 = IF).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_if_arvalid  in  1  fetch read request
- o_if_arready  out  1  fetch request accepted (1-cycle pulse)
- i_if_araddr  in  XLEN  fetch address
- i_if_arprot  in  3  fetch protection (normally 3'b100)
- o_if_rvalid  out  1  fetch response valid
- i_if_rready  in  1  fetch response ready
- o_if_rdata  out  XLEN  fetch response data
- o_if_rresp  out  2  fetch response status
- i_ls_arvalid, o_ls_arready, i_ls_araddr, i_ls_arprot, o_ls_rvalid, i_ls_rready, o_ls_rdata, o_ls_rresp: same widths and meanings for the load requester
- o_m_arvalid  out  1  downstream AR valid
- i_m_arready  in  1  downstream AR ready
- o_m_araddr  out  XLEN  downstream address
- o_m_arprot  out  3  downstream protection
- i_m_rvalid  in  1  downstream R valid
- o_m_rready  out  1  downstream R ready
- i_m_rdata  in  XLEN  downstream data
- i_m_rresp  in  2  downstream response
- o_owner  out  2  debug: 2'b00 none, 2'b01 IF, 2'b10 LS

Behaviour:
- Reset (async assert, sync deassert use): state IDLE, o_m_arvalid=0, o_m_araddr=0, o_m_arprot=0, owner=none, last_grant initialised so the LS_FIRST requester wins the first tie.
- All outputs are 0 during reset.
- States:
  - IDLE: no transaction.
  - ADDR: presenting AR downstream.
  - RESP: waiting for/routing R.
- IDLE:
  - If any i_x_arvalid, pick the winner. Single requester wins outright. If both request, the requester not equal to last_grant wins.
  - Combinationally pulse o_x_arready for the winner only, in the same cycle.
  - Register i_x_araddr/arprot into o_m_araddr/arprot, set owner, go to ADDR.
  - Loser's arready stays 0; its request must hold (AXI rule).
- ADDR:
  - o_m_arvalid=1, address and prot stable.
  - On i_m_arvalid&&i_m_arready (sampled at the clock edge), drop o_m_arvalid next cycle and go to RESP.
  - Holds indefinitely while arready=0.
- RESP:
  - o_owner_rvalid = i_m_rvalid; o_m_rready = i_owner_rready (combinational). Non-owner rvalid=0.
  - rdata/rresp go to both requesters unqualified.
  - On i_m_rvalid&&o_m_rready: last_grant<=owner, owner<=none, go to IDLE.
- Latency:
  - Request seen in IDLE at cycle N: o_m_arvalid=1 at N+1.
  - Earliest next grant is the cycle after the R handshake.
  - Minimum 3 cycles per transaction with zero-wait memory.
- Starvation bound: a continuously asserted requester waits at most one transaction of the other.
- Boundaries:
  - i_m_rvalid outside RESP is ignored; o_m_rready=0 there.
  - rresp≠OKAY is forwarded unchanged; the arbiter does not retry.
  - Requester dropping arvalid before grant is tolerated (no grant issued).
  - Reset mid-ADDR/RESP: immediate return to IDLE, o_m_arvalid=0, owner cleared; the downstream is reset on the same rstn.
  - Simultaneous R handshake and new arvalid: grant deferred to the next IDLE cycle.

Decomposition:
- riscv_pkg gains:
  - typedef enum logic [1:0] arb_state_e {ArbIdle, ArbAddr, ArbResp}
  - typedef enum logic [1:0] arb_owner_e {OwnNone, OwnIF, OwnLS}
  - constant RespOKAY=2'b00
- Sub-module rr_arbiter2: combinational two-request round-robin pick from (req[1:0], last_grant), returning a one-hot grant. Reusable for the future write-channel arbiter.

Test Plan:
- Reset, then IF only, araddr=0x0000_0000, arprot=3'b100, memory arready=1, rvalid 1 cycle later with rdata=0x0000_0013 -> o_if_arready pulse at cycle 0, o_m_arvalid cycle 1, o_if_rvalid=1 with rdata 0x13, o_owner returns 00, LS never sees rvalid.
- Both request continuously (IF 0x0000_0100, LS 0x0000_2000), LS_FIRST=1 -> downstream addresses in order 0x2000, 0x100, 0x2000, 0x100; each requester gets exactly one arready per grant.
- Memory holds arready=0 for 5 cycles -> o_m_arvalid stays 1 with araddr/arprot stable for all 5, then drops one cycle after arready.
- In RESP, owner IF holds i_if_rready=0 for 3 cycles while i_m_rvalid=1, rdata=0xDEAD_BEEF -> o_m_rready=0, no state change; handshake on the 4th cycle returns to IDLE.
- Assert rstn=0 mid-ADDR -> o_m_arvalid=0 asynchronously, owner=00. After release, a pending LS request is granted first.
- i_m_rvalid=1 while IDLE and rresp=2'b10 in RESP -> no requester rvalid in IDLE; SLVERR is forwarded to the owner in RESP.
